// File: rtl/btn_conditioner.sv
// Two-button conditioner: synchronize, debounce and turn presses into one-cycle move pulses.
// Define BTN_AUTOREPEAT_EN for hold-to-repeat; otherwise one pulse per press.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter bit          BTN_POL_LOW     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_out,
  output logic [1:0] btn_level
);

  // state    | meaning
  // IDLE     | button released, waiting for debounced level to rise
  // PRESS    | first pulse of a press
  // DELAY    | held, counting down to the first auto-repeat (autorepeat build)
  // REPEAT   | held, pulsing every REPEAT_PERIOD cycles (autorepeat build)
  // WAIT_REL | held, no further pulses until release (single-pulse build)
`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_DELAY, S_REPEAT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_WAIT_REL} state_t;
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync1_q, sync2_q, btn_sync;
  logic [1:0]      level_q, level_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  state_t          state_q  [2];
  state_t          state_d  [2];
  logic [1:0]      pulse;
  logic [1:0]      out_q, out_d;

  assign btn_sync  = BTN_POL_LOW ? ~sync2_q : sync2_q;
  assign btn_level = level_q;
  assign btn_out   = out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (btn_sync[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) level_d[i] = ~level_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  // The PRESS cycle counts toward the delay; a delay of 1 still leaves a gap between pulses.
  localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'((REPEAT_DELAY > 1) ? REPEAT_DELAY - 2 : 0);
  localparam logic [TMR_W-1:0] PER_LOAD = TMR_W'(REPEAT_PERIOD - 1);

  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];

  always_comb begin
    pulse = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      if (!level_q[i]) begin
        state_d[i] = S_IDLE;
        tmr_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            state_d[i] = S_PRESS;
            pulse[i]   = 1'b1;
          end
          S_PRESS: begin
            state_d[i] = S_DELAY;
            tmr_d[i]   = DLY_LOAD;
          end
          S_DELAY, S_REPEAT: begin
            if (tmr_q[i] == '0) begin
              state_d[i] = S_REPEAT;
              tmr_d[i]   = PER_LOAD;
              pulse[i]   = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] - 1'b1;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            tmr_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) tmr_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) tmr_q[i] <= tmr_d[i];
    end
  end
`else
  always_comb begin
    pulse = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      if (!level_q[i]) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            state_d[i] = S_PRESS;
            pulse[i]   = 1'b1;
          end
          S_PRESS:    state_d[i] = S_WAIT_REL;
          S_WAIT_REL: state_d[i] = S_WAIT_REL;
          default:    state_d[i] = S_IDLE;
        endcase
      end
    end
  end
`endif

  // Suppress a pulse landing in the cycle the level drops, and both-held chords.
  always_comb begin
    out_d = pulse & level_d;
    if (level_d == 2'b11) out_d = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 2'b00;
      out_q   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i]  <= S_IDLE;
      end
    end else begin
      level_q <= level_d;
      out_q   <= out_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning cycles the synchronized input must be stable before the debounced level changes (min 1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning cycles from press pulse to first auto-repeat pulse (min 1).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2500000, meaning cycles between consecutive auto-repeat pulses (min 1).
REQ-004 SHALL have parameter BTN_POL_LOW, default 0, meaning 1 = raw buttons are pressed-low and are inverted after synchronization.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port btn_raw  input  2  raw asynchronous buttons; bit0 = decrement/left/up, bit1 = increment/right/down.
REQ-008 SHALL have port btn_out  output  2  one-cycle move pulses; drives the downstream movement controller's btn input.
REQ-009 SHALL have port btn_level  output  2  debounced, polarity-corrected button level.

Function
REQ-010 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep one debounce counter per bit: counter increments while synchronized value differs from btn_level; counter clears when they match.
REQ-012 SHALL toggle btn_level on the edge where the counter reaches DEBOUNCE_CYCLES, then clear the counter; any mismatch gap before that restarts counting from 0.
REQ-013 SHALL size every counter to hold its parameter's maximum value without wrap.
REQ-014 SHALL run one FSM per bit with states IDLE, PRESS, DELAY, REPEAT, all transitions on clk.
REQ-015 SHALL transition IDLE->PRESS on the cycle after btn_level rises; PRESS lasts exactly one cycle with pulse asserted.
REQ-016 SHALL transition PRESS->DELAY, count REPEAT_DELAY cycles, then enter REPEAT and assert one pulse.
REQ-017 SHALL, in REPEAT, assert one pulse every REPEAT_PERIOD cycles while btn_level remains high.
REQ-018 SHALL return any state to IDLE on the cycle after btn_level falls, with no pulse in that cycle; delay/period counters clear.
REQ-019 SHALL register btn_out (pulse visible the cycle the FSM is in PRESS or a REPEAT pulse cycle); btn_out never asserted longer than one consecutive cycle per event.
REQ-020 SHALL mask btn_out to 2'b00 while both btn_level bits are high; FSMs keep running unmasked internally.
REQ-021 SHALL treat a button held through reset release as a new press: btn_level rises after debounce and a PRESS pulse follows.

Reset
REQ-022 SHALL, while reset is low, asynchronously force synchronizers, btn_level, btn_out to 2'b00, all counters to 0, all FSMs to IDLE.
REQ-023 SHALL abort any in-progress debounce, delay or repeat immediately on reset assertion, with no residual pulse after release.
REQ-024 SHALL resume normal operation on the first rising clk after reset deasserts.

Configuration
REQ-025 SHALL, when macro BTN_AUTOREPEAT_EN is defined, implement DELAY and REPEAT as above.
REQ-026 SHALL, when BTN_AUTOREPEAT_EN is undefined, replace DELAY/REPEAT with a single WAIT_RELEASE state: exactly one pulse per press, none while held; REPEAT_DELAY and REPEAT_PERIOD ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_POL_LOW=0)
REQ-027 SHALL cover: btn_raw[0] 0->1 held -> btn_level[0] high 6 edges after first sampling edge (2 sync + 4 debounce), btn_out[0] one-cycle pulse on edge 7.
REQ-028 SHALL cover: btn_raw[1] glitch high 3 cycles then low -> btn_level[1] and btn_out[1] stay 0.
REQ-029 SHALL cover (BTN_AUTOREPEAT_EN defined): btn_raw[0] held 40 cycles -> press pulse, next pulse 10 cycles later, then pulses every 3 cycles; release -> no pulse after btn_level falls.
REQ-030 SHALL cover (BTN_AUTOREPEAT_EN undefined): btn_raw[0] held 40 cycles -> exactly one btn_out[0] pulse.
REQ-031 SHALL cover: both buttons pressed together -> btn_level=2'b11, btn_out=2'b00 throughout.
REQ-032 SHALL cover: reset driven low mid-REPEAT with button held -> btn_out=0 and btn_level=0 immediately; after release a fresh press pulse follows 7 edges later.
